// File: rtl/id_stage_pipelined_pkg.sv
// Shared encodings and instruction field layout for the pipelined decode stage.
package id_stage_pipelined_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_JUMP   = 2'd1,
    PCSRC_BRANCH = 2'd2,
    PCSRC_JR     = 2'd3
  } pc_src_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_WB   = 2'd1,
    FWD_EX   = 2'd2,
    FWD_ZERO = 2'd3
  } fwd_sel_e;

  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int FIELD_W = 5;
  localparam int IMM_W   = 16;
  localparam int JIDX_W  = 26;

endpackage

// File: rtl/id_regfile.sv
// Register bank: sync write, async dual read, r0 hardwired to zero, optional WB bypass.
module id_regfile #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [REG_ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [1:0][REG_ADDR_W-1:0] raddr,
  output logic [1:0][DATA_W-1:0]     rdata
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk) begin
    if (reset)
      regs <= '0;
    else if (we && waddr != '0 && int'(waddr) < NUM_REGS)
      regs[waddr] <= wdata;
  end

  // Addresses beyond NUM_REGS read as zero, like r0.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      if (raddr[p] != '0 && int'(raddr[p]) < NUM_REGS) begin
        if (BYPASS_EN && we && raddr[p] == waddr)
          rdata[p] = wdata;
        else
          rdata[p] = regs[raddr[p]];
      end
    end
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// MIPS-style decode stage: operand read/forward, branch resolve, hazard stall, ID/EX register.
module id_stage_pipelined
  import id_stage_pipelined_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [31:0]           in_inst,
  input  logic                  sign_ext_ctrl,
  input  logic [1:0]            pc_src,
  input  logic                  br_ne,
  input  logic [1:0]            fwd_sel_a,
  input  logic [1:0]            fwd_sel_b,
  input  logic [DATA_W-1:0]     ex_fwd_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  output logic                  stall,
  output logic                  flush_if,
  output logic [DATA_W-1:0]     pc_next,
  output logic                  cmp_eq,
  output logic                  idex_valid,
  output logic [DATA_W-1:0]     idex_pc,
  output logic [DATA_W-1:0]     idex_rs_data,
  output logic [DATA_W-1:0]     idex_rt_data,
  output logic [DATA_W-1:0]     idex_imm,
  output logic [REG_ADDR_W-1:0] idex_rs,
  output logic [REG_ADDR_W-1:0] idex_rt,
  output logic [REG_ADDR_W-1:0] idex_rd
);

  function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                input logic [DATA_W-1:0] rf,
                                                input logic [DATA_W-1:0] wb,
                                                input logic [DATA_W-1:0] ex);
    case (sel)
      FWD_RF:  return rf;
      FWD_WB:  return wb;
      FWD_EX:  return ex;
      default: return '0;
    endcase
  endfunction

  logic [REG_ADDR_W-1:0]     rs, rt, rd;
  logic [1:0][DATA_W-1:0]    rf_rdata;
  logic [DATA_W-1:0]         imm, br_tgt, j_tgt, opa, opb;
  logic                      hz_rs, hz_rt, load_use, br_dep, taken, redirect, cap_en;
  logic                      unused_opcode;

  assign rs = REG_ADDR_W'(in_inst[RS_LSB +: FIELD_W]);
  assign rt = REG_ADDR_W'(in_inst[RT_LSB +: FIELD_W]);
  assign rd = REG_ADDR_W'(in_inst[RD_LSB +: FIELD_W]);
  assign unused_opcode = ^in_inst[31:JIDX_W];

  id_regfile #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)
  ) u_rf (
    .clk(clk), .reset(reset),
    .we(wb_we), .waddr(wb_addr), .wdata(wb_data),
    .raddr({rt, rs}), .rdata(rf_rdata)
  );

  assign imm    = {{(DATA_W-IMM_W){sign_ext_ctrl & in_inst[IMM_W-1]}}, in_inst[IMM_W-1:0]};
  assign br_tgt = in_pc + (imm << 2);
  assign j_tgt  = {in_pc[DATA_W-1:28], in_inst[JIDX_W-1:0], 2'b00};

  assign opa    = fwd_mux(fwd_sel_a, rf_rdata[0], wb_data, ex_fwd_data);
  assign opb    = fwd_mux(fwd_sel_b, rf_rdata[1], wb_data, ex_fwd_data);
  assign cmp_eq = (opa == opb);
  assign taken  = cmp_eq ^ br_ne;

  // The comparator lives in ID, so a branch/jr cannot consume an EX result yet.
  assign hz_rs    = (rs != '0) && (ex_dst == rs);
  assign hz_rt    = (rt != '0) && (ex_dst == rt);
  assign load_use = ex_mem_read & (hz_rs | hz_rt);
  assign br_dep   = (pc_src == PCSRC_BRANCH || pc_src == PCSRC_JR) & ex_reg_write & (hz_rs | hz_rt);
  assign stall    = ~reset & in_valid & (load_use | br_dep);

  assign redirect = (pc_src == PCSRC_JUMP) || (pc_src == PCSRC_JR) ||
                    (pc_src == PCSRC_BRANCH && taken);
  assign flush_if = ~reset & in_valid & ~stall & redirect;
  assign cap_en   = in_valid & ~stall;

  always_comb begin
    pc_next = in_pc;
    if (stall)
      pc_next = in_pc - DATA_W'(4);
    else begin
      case (pc_src)
        PCSRC_JUMP:   pc_next = j_tgt;
        PCSRC_BRANCH: pc_next = taken ? br_tgt : in_pc;
        PCSRC_JR:     pc_next = opa;
        default:      pc_next = in_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !cap_en) begin
      idex_valid   <= 1'b0;
      idex_pc      <= '0;
      idex_rs_data <= '0;
      idex_rt_data <= '0;
      idex_imm     <= '0;
      idex_rs      <= '0;
      idex_rt      <= '0;
      idex_rd      <= '0;
    end else begin
      idex_valid   <= 1'b1;
      idex_pc      <= in_pc;
      idex_rs_data <= opa;
      idex_rt_data <= opb;
      idex_imm     <= imm;
      idex_rs      <= rs;
      idex_rt      <= rt;
      idex_rd      <= rd;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed pins plus randomized traffic against a behavioural model.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset, in_valid, sign_ext_ctrl, br_ne, wb_we, ex_mem_read, ex_reg_write;
  logic [31:0] in_pc, in_inst, ex_fwd_data, wb_data;
  logic [1:0]  pc_src, fwd_sel_a, fwd_sel_b;
  logic [4:0]  wb_addr, ex_dst;
  logic        stall, flush_if, cmp_eq, idex_valid;
  logic [31:0] pc_next, idex_pc, idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipelined dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .sign_ext_ctrl(sign_ext_ctrl), .pc_src(pc_src), .br_ne(br_ne),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_dst(ex_dst),
    .stall(stall), .flush_if(flush_if), .pc_next(pc_next), .cmp_eq(cmp_eq),
    .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs_data(idex_rs_data),
    .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mregs [32];
  bit          have_exp = 0;
  logic        e_valid;
  logic [31:0] e_pc, e_rs_data, e_rt_data, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return 32'd0;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic logic [31:0] m_opnd(input logic [1:0] sel, input int a);
    case (sel)
      2'd0:    return m_read(a);
      2'd1:    return wb_data;
      2'd2:    return ex_fwd_data;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    int          rs, rt, rd, dst;
    logic [31:0] a, b, imm, exp_pc;
    bit          eq, tk, hz, redir;
    if (have_exp) begin
      chk("idex_valid",   {31'd0, idex_valid}, {31'd0, e_valid});
      chk("idex_pc",      idex_pc, e_pc);
      chk("idex_rs_data", idex_rs_data, e_rs_data);
      chk("idex_rt_data", idex_rt_data, e_rt_data);
      chk("idex_imm",     idex_imm, e_imm);
      chk("idex_regs",    {17'd0, idex_rs, idex_rt, idex_rd}, {17'd0, e_rs, e_rt, e_rd});
    end
    rs  = int'(in_inst[25:21]);
    rt  = int'(in_inst[20:16]);
    rd  = int'(in_inst[15:11]);
    dst = int'(ex_dst);
    if (sign_ext_ctrl) imm = 32'($signed(in_inst[15:0]));
    else               imm = 32'(in_inst[15:0]);
    a  = m_opnd(fwd_sel_a, rs);
    b  = m_opnd(fwd_sel_b, rt);
    eq = (a == b);
    tk = br_ne ? !eq : eq;
    hz = in_valid && !reset && dst != 0 && (dst == rs || dst == rt) &&
         (ex_mem_read || (ex_reg_write && pc_src >= 2'd2));
    redir = (pc_src == 2'd1) || (pc_src == 2'd3) || (pc_src == 2'd2 && tk);
    if (hz)                 exp_pc = in_pc - 32'd4;
    else if (pc_src == 2'd1) exp_pc = (in_pc & 32'hF000_0000) | (32'(in_inst[25:0]) * 32'd4);
    else if (pc_src == 2'd2) exp_pc = tk ? in_pc + imm * 32'd4 : in_pc;
    else if (pc_src == 2'd3) exp_pc = a;
    else                     exp_pc = in_pc;
    chk("stall",    {31'd0, stall},    {31'd0, hz});
    chk("flush_if", {31'd0, flush_if}, {31'd0, in_valid && !reset && !hz && redir});
    chk("pc_next",  pc_next, exp_pc);
    chk("cmp_eq",   {31'd0, cmp_eq},   {31'd0, eq});
    if (reset || !in_valid || hz) begin
      e_valid = 0; e_pc = 0; e_rs_data = 0; e_rt_data = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0;
    end else begin
      e_valid = 1; e_pc = in_pc; e_rs_data = a; e_rt_data = b; e_imm = imm;
      e_rs = 5'(rs); e_rt = 5'(rt); e_rd = 5'(rd);
    end
    have_exp = 1;
    // Inputs hold until the next rising edge, so the register write can be applied now.
    if (reset) for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    else if (wb_we && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk_r(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; in_pc = 0; in_inst = 0; sign_ext_ctrl = 1; pc_src = 0; br_ne = 0;
    fwd_sel_a = 0; fwd_sel_b = 0; ex_fwd_data = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1; drive_idle(); fwd_sel_a = 3; fwd_sel_b = 3;
    next_cyc(); next_cyc();
    chk("rst_idex_valid", {31'd0, idex_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    reset = 0; fwd_sel_a = 0; fwd_sel_b = 0;

    // write r5 then decode add rd,r5,r0
    wb_we = 1; wb_addr = 5; wb_data = 32'hAA; next_cyc();
    wb_we = 0; in_valid = 1; in_pc = 32'h40; in_inst = mk_r(5, 0, 9);
    peek(); chk("seq_pc", pc_next, 32'h40);
    next_cyc();
    chk("r5_read", idex_rs_data, 32'hAA); chk("r5_valid", {31'd0, idex_valid}, 32'd1);
    chk("r5_rd", {27'd0, idex_rd}, 32'd9);

    // same-cycle bypass, then r0 write ignored
    wb_we = 1; wb_addr = 7; wb_data = 32'h1234; in_inst = mk_r(7, 0, 1); next_cyc();
    chk("bypass_r7", idex_rs_data, 32'h1234);
    wb_addr = 0; wb_data = 32'hFFFF_FFFF; in_inst = mk_r(0, 7, 2); next_cyc();
    chk("r0_bypass", idex_rs_data, 32'h0); chk("r7_kept", idex_rt_data, 32'h1234);
    wb_we = 0; next_cyc();
    chk("r0_after", idex_rs_data, 32'h0);

    // load-use
    ex_mem_read = 1; ex_dst = 3; in_inst = mk_r(3, 0, 4); in_pc = 32'h80;
    peek(); chk("lu_stall", {31'd0, stall}, 32'd1); chk("lu_pc", pc_next, 32'h7C);
    next_cyc(); chk("lu_bubble", {31'd0, idex_valid}, 32'd0);
    ex_mem_read = 0;
    peek(); chk("lu_clear", {31'd0, stall}, 32'd0);
    next_cyc(); chk("lu_capture", {27'd0, idex_rs}, 32'd3);

    // branch dependency
    pc_src = 2; ex_reg_write = 1; ex_dst = 3;
    peek(); chk("brdep_stall", {31'd0, stall}, 32'd1);
    next_cyc();

    // beq taken / bne not taken / zero-extended offset
    ex_reg_write = 0; ex_dst = 0; fwd_sel_a = 2; fwd_sel_b = 2; ex_fwd_data = 32'h10;
    in_pc = 32'h100; in_inst = {6'd4, 5'd1, 5'd2, 16'hFFFF};
    peek(); chk("beq_pc", pc_next, 32'hFC); chk("beq_flush", {31'd0, flush_if}, 32'd1);
    next_cyc(); chk("beq_imm", idex_imm, 32'hFFFF_FFFF);
    br_ne = 1;
    peek(); chk("bne_pc", pc_next, 32'h100); chk("bne_flush", {31'd0, flush_if}, 32'd0);
    next_cyc();
    br_ne = 0; sign_ext_ctrl = 0;
    peek(); chk("zext_pc", pc_next, 32'h400FC);
    next_cyc(); chk("zext_imm", idex_imm, 32'h0000_FFFF);

    // jump and jr
    sign_ext_ctrl = 1; pc_src = 1; in_pc = 32'hA000_0004; in_inst = {6'd2, 26'h10};
    peek(); chk("j_pc", pc_next, 32'hA000_0040); chk("j_flush", {31'd0, flush_if}, 32'd1);
    next_cyc();
    pc_src = 3; fwd_sel_a = 1; wb_data = 32'h400;
    peek(); chk("jr_pc", pc_next, 32'h400);
    next_cyc();

    // reset mid-stream
    reset = 1; pc_src = 1; fwd_sel_a = 0; fwd_sel_b = 0; in_inst = mk_r(5, 7, 6);
    peek(); chk("rstm_flush", {31'd0, flush_if}, 32'd0);
    next_cyc(); chk("rstm_valid", {31'd0, idex_valid}, 32'd0); chk("rstm_pc", idex_pc, 32'd0);
    reset = 0; pc_src = 0;
    next_cyc(); chk("rstm_r5", idex_rs_data, 32'd0); chk("rstm_r7", idex_rt_data, 32'd0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset         = ($urandom_range(0, 63) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      r = $urandom(); in_pc = r & 32'hFFFF_FFFC;
      r = $urandom();
      r[25:21] = 5'($urandom_range(0, 7)); r[20:16] = 5'($urandom_range(0, 7));
      in_inst       = r;
      sign_ext_ctrl = 1'($urandom_range(0, 1));
      pc_src        = 2'($urandom_range(0, 3));
      br_ne         = 1'($urandom_range(0, 1));
      fwd_sel_a     = 2'($urandom_range(0, 3));
      fwd_sel_b     = 2'($urandom_range(0, 3));
      ex_fwd_data   = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom();
      wb_we         = 1'($urandom_range(0, 1));
      wb_addr       = 5'($urandom_range(0, 7));
      wb_data       = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom();
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_dst        = 5'($urandom_range(0, 7));
      next_cyc();
    end
    reset = 0; drive_idle();
    next_cyc(); next_cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised successor to the MIPS decode stage.
- Contains:
  - register bank with write-through bypass;
  - sign/zero extender;
  - branch/jump target generation;
  - forwarding muxes;
  - branch comparator (beq/bne);
  - load-use and branch-dependency hazard detection;
  - registered ID/EX pipeline boundary with bubble insertion.
- Sits between the IF/ID register and the EX stage.
- Drives next-PC selection, the stall signal and the IF flush back to fetch.

Parameters:
- DATA_W, 32, datapath/register width; must be ≥ 32.
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, register count; must be ≤ 2**REG_ADDR_W.
- BYPASS_EN, 1, enables same-cycle write-through when the WB address equals a read address.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds a real instruction
- in_pc  in  DATA_W  PC+4 of the instruction in ID
- in_inst  in  32  instruction word
- sign_ext_ctrl  in  1  1=sign-extend imm16, 0=zero-extend
- pc_src  in  2  0=seq, 1=jump, 2=branch, 3=jr (register)
- br_ne  in  1  branch sense when pc_src=2: 0=beq, 1=bne
- fwd_sel_a, fwd_sel_b  in  2 each  0=regfile, 1=wb_data, 2=ex_fwd_data, 3=zero
- ex_fwd_data  in  DATA_W  EX/MEM result for forwarding
- wb_we  in  1  writeback enable
- wb_addr  in  REG_ADDR_W  writeback address
- wb_data  in  DATA_W  writeback data
- ex_mem_read  in  1  instruction in EX is a load
- ex_reg_write  in  1  instruction in EX writes a register
- ex_dst  in  REG_ADDR_W  destination register of the EX instruction
- stall  out  1  freeze PC and IF/ID this cycle
- flush_if  out  1  squash the instruction in IF/ID next cycle
- pc_next  out  DATA_W  selected next PC
- cmp_eq  out  1  forwarded A == forwarded B
- idex_valid  out  1  ID/EX holds a real instruction
- idex_pc, idex_rs_data, idex_rt_data, idex_imm  out  DATA_W each  registered ID/EX values
- idex_rs, idex_rt, idex_rd  out  REG_ADDR_W each  registered register addresses

Behaviour:
- Register file:
  - Written on the rising edge when wb_we=1 and wb_addr≠0.
  - Register 0 always reads 0.
  - Reads are asynchronous.
  - With BYPASS_EN=1, a read of wb_addr (≠0) while wb_we=1 returns wb_data in the same cycle.
  - reset clears all registers to 0.
- Fields:
  - rs=inst[25:21], rt=inst[20:16], rd=inst[15:11].
  - Upper address bits are zero-padded when REG_ADDR_W>5.
- Immediate: inst[15:0] sign- or zero-extended to DATA_W per sign_ext_ctrl.
- Branch target: in_pc + (imm << 2), modulo 2**DATA_W (wrap, no trap).
- Jump target: {in_pc[DATA_W-1:28], inst[25:0], 2'b00}.
- Forwarding: A/B are taken from the fwd_sel mux (code 3 forces 0). cmp_eq compares the forwarded A and B.
- Hazards (evaluated only when in_valid=1; rs/rt equal to 0 never cause a hazard):
  - Load-use: ex_mem_read=1 and ex_dst∈{rs,rt} → stall=1.
  - Branch dependency: pc_src∈{2,3}, ex_reg_write=1 and ex_dst∈{rs,rt} → stall=1. The EX result is not yet available in ID.
- pc_next:
  - stall=1 → in_pc−4, i.e. hold the current fetch.
  - Otherwise: seq → in_pc; jump → jump target; branch → taken ? branch target : in_pc; jr → forwarded A.
  - taken = cmp_eq XOR br_ne.
- flush_if = in_valid & ~stall & (pc_src=1 | pc_src=3 | (pc_src=2 & taken)). It is zero during reset.
- ID/EX register, one-cycle latency, updated every clock:
  - stall=1 or in_valid=0 → bubble: idex_valid=0 and all idex_* data/address outputs 0.
  - Otherwise all idex_* outputs capture the current values and idex_valid=1.
- Reset: all idex_* outputs go to 0 on the next edge; stall and flush_if are forced to 0 while reset=1.
- Simultaneous WB write and read of the same register with BYPASS_EN=0: the old value is read and the new value is visible next cycle.
- A stalled instruction re-evaluates every cycle. The stall clears once the hazard source leaves EX; no internal counter is kept.

Decomposition:
- Shared package holds:
  - pc_src encoding constants (PCSRC_SEQ/JUMP/BRANCH/JR);
  - forwarding select codes (FWD_RF/WB/EX/ZERO);
  - instruction field bit positions;
  - the default DATA_W.
- One natural sub-module: id_regfile (parametrised register bank with bypass). Hazard detection and muxes stay inline.

Test Plan:
- Write r5=0x0000_00AA (wb_we=1), then decode "add rd,r5,r0" → idex_rs_data=0xAA after 1 cycle, idex_valid=1.
- Same cycle: wb_we=1, wb_addr=7, wb_data=0x1234; inst reads r7 with BYPASS_EN=1 → idex_rs_data=0x1234. Write to r0 → r0 still reads 0.
- Load-use: ex_mem_read=1, ex_dst=3, inst rs=3 → stall=1, pc_next=in_pc−4, next-cycle idex_valid=0. Hazard removed → normal capture.
- beq, A=B=0x10 via fwd_sel=2, in_pc=0x100, imm=0xFFFF (sign) → taken, pc_next=0x0FC, flush_if=1. Same with br_ne=1 → pc_next=0x100, flush_if=0.
- jump, in_pc=0xA000_0004, inst[25:0]=0x000_0010 → pc_next=0xA000_0040, flush_if=1. jr with fwd_sel_a=1, wb_data=0x400 → pc_next=0x400.
- Assert reset mid-stream with in_valid=1 → next edge all idex_*=0, stall=0, flush_if=0, regfile reads 0.
